ff_bank: RTL

- Parametrised bank of WIDTH independent flip-flop channels sharing one clock.
- Each channel behaves as a D, T, SR or JK flip-flop, selected by a runtime mode input common to the bank.
- SR illegal input resolves deterministically per SR_POLICY; there is no X state.
- Illegal SR/JK-style events are tracked with sticky per-channel flags and a saturating bank-wide counter.
- Serves as the generic storage/toggle primitive for control registers and small state elements.

---
 rtl/ff_bank_pkg.sv | 12 +
 rtl/ff_bank_cell.sv | 56 +++++
 rtl/ff_bank.sv | 71 +++++++
 3 files changed

// File: rtl/ff_bank_pkg.sv
// Shared types for the ff_bank flip-flop bank: mode and SR-conflict policy encodings.
package ff_bank_pkg;

  typedef enum logic [1:0] {FF_D, FF_T, FF_SR, FF_JK} ff_mode_e;
  typedef enum logic [1:0] {SR_HOLD, SR_SET, SR_RST} sr_policy_e;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_SR = 2'b10;
  localparam logic [1:0] MODE_JK = 2'b11;

endpackage

// File: rtl/ff_bank_cell.sv
// Single ff_bank channel: D/T/SR/JK next-state logic, state register and SR-conflict detect.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic       RESET_VAL = 1'b0,
  parameter sr_policy_e SR_POLICY = SR_HOLD
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       nxt,
  output logic       q,
  output logic       conflict
);

  logic d;

  always_comb begin
    d = q;
    case (ff_mode_e'(mode))
      FF_D:  d = a;
      FF_T:  d = q ^ a;
      FF_SR: begin
        case ({a, b})
          2'b01:   d = 1'b0;
          2'b10:   d = 1'b1;
          2'b11:   d = (SR_POLICY == SR_SET) ? 1'b1 :
                       (SR_POLICY == SR_RST) ? 1'b0 : q;
          default: d = q;
        endcase
      end
      FF_JK: begin
        case ({a, b})
          2'b01:   d = 1'b0;
          2'b10:   d = 1'b1;
          2'b11:   d = ~q;
          default: d = q;
        endcase
      end
      default: d = q;
    endcase
  end

  // Enable is folded here so the parity path sees exactly what gets loaded.
  assign nxt      = en ? d : q;
  assign conflict = (mode == MODE_SR) && a && b;

  always_ff @(posedge clk) begin
    if (!rstn) q <= RESET_VAL;
    else       q <= nxt;
  end

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH ff_cell channels with sticky SR-conflict flags and a saturating counter.
// Optional FF_BANK_PARITY_EN adds a registered q_par output tracking ^q.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter sr_policy_e       SR_POLICY = SR_HOLD,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
`ifdef FF_BANK_PARITY_EN
  output logic             q_par,
`endif
  output logic [WIDTH-1:0] illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] conflict;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RESET_VAL (RESET_VAL[i]),
      .SR_POLICY (SR_POLICY)
    ) u_cell (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .mode     (mode),
      .a        (a[i]),
      .b        (b[i]),
      .nxt      (nxt[i]),
      .q        (q[i]),
      .conflict (conflict[i])
    );
  end

  assign q_bar = ~q;

  // Clear beats a same-edge conflict; the event is dropped, not deferred.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      illegal     <= '0;
      illegal_cnt <= '0;
    end else if (clr_err) begin
      illegal     <= '0;
      illegal_cnt <= '0;
    end else if (en) begin
      illegal <= illegal | conflict;
      if (|conflict && illegal_cnt != {CNT_W{1'b1}})
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

`ifdef FF_BANK_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) q_par <= ^RESET_VAL;
    else       q_par <= ^nxt;
  end
`endif

endmodule
